rvfi_order_serializer: RTL and testbench
========================================

// Module: rvfi_order_serializer
// PURPOSE
// - Merges NRET out-of-order RVFI retirement channels into one in-order channel.
// - Output rvfi_order values are strictly consecutive from 0, one retirement per cycle max.
// - Sits between the core's RVFI port and single-channel checkers, e.g. the
//   uniqueness and PC-forward checks.
// - Raises sticky error flags for duplicate, stale or out-of-window order values.
// PARAMETERS
// NRET       2    number of input retirement channels
// PAYLOAD_W  128  per-channel opaque payload bits (insn, pc_rdata, pc_wdata, ...)
// DEPTH      8    reorder window in entries; power of two, >= NRET
// PORTS
// clock        in   1             single clock; all state updates on posedge
// reset_n      in   1             synchronous, active-low reset
// in_valid     in   NRET          per-channel retirement valid
// in_order     in   64*NRET       per-channel rvfi_order, channel i at [64*i +: 64]
// in_payload   in   PAYLOAD_W*NRET per-channel payload, channel i at [PAYLOAD_W*i +: PAYLOAD_W]
// out_valid    out  1             serialized retirement valid (registered)
// out_order    out  64            serialized order (registered)
// out_payload  out  PAYLOAD_W     serialized payload (registered)
// next_order   out  64            next order value awaiting emission
// err_dup      out  1             sticky: order already buffered, already emitted, or repeated in one cycle
// err_ovf      out  1             sticky: order >= next_order+DEPTH, so the entry is dropped
// BEHAVIOUR
// - Reset (reset_n==0 at posedge) clears all outputs, slot valid bits and the errors;
//   next_order=0. Reset mid-operation discards all buffered entries; no output that cycle.
// - Storage: DEPTH slots, each {vld, order, payload}, indexed by order[log2(DEPTH)-1:0].
// - Per posedge, for each channel i with in_valid[i]:
//   - order < next_order, slot already vld, or equal to a lower-index channel's order:
//     set err_dup, drop entry.
//   - order >= next_order+DEPTH: set err_ovf, drop entry. Compare as 65-bit unsigned; no wrap.
//   - otherwise write the slot and set vld.
// - Emission: at each posedge, if head slot (next_order mod DEPTH) was vld before this edge:
//   - out_valid<=1, out_order/out_payload<=slot contents;
//   - clear slot vld, next_order<=next_order+1.
//   - else out_valid<=0; out_order/out_payload hold their last values.
// - A write and an emission to the same slot in one edge cannot collide: the window rule
//   forbids it. The head is only writable when it is empty.
// - Latency: input at edge t is visible on out_* after edge t+1 (base build).
// - No backpressure exists. Sustained retirement >1/cycle fills the window and trips err_ovf.
// - Errors stay set until reset. Normal operation continues after an error.
// CONFIGURATION
// - RVFI_SERIALIZER_BYPASS_EN defined:
//   - a valid input with order==next_order while the head slot is empty loads out_* directly
//     at the same edge, and next_order increments. Latency is 1 edge; the slot is not written.
//   - Only one bypass per edge; other channels follow the normal slot rules.
// - Not defined: no bypass; every entry passes through a slot (latency 2 edges).
// TESTING
// - In-order single channel: orders 0,1,2 on ch0 over 3 cycles
//   -> out_order 0,1,2 on consecutive cycles from edge 2 (edge 1 with BYPASS_EN), no errors.
// - Swap: cycle0 ch0=1, ch1=0; cycle1 ch0=3, ch1=2
//   -> out_order 0,1,2,3 back-to-back, next_order=4.
// - Duplicate: order 0 on ch0 and ch1 in one cycle -> one out_order 0, err_dup=1.
//   Later order 0 again -> err_dup stays 1, nothing emitted.
// - Overflow: with next_order=0, DEPTH=8, inject order 8 -> err_ovf=1, dropped.
//   Order 7 is accepted and emitted after orders 0..6.
// - Reset mid-operation: buffer orders 1,2 (0 missing), pulse reset_n low 1 cycle
//   -> out_valid=0, next_order=0, errors 0. Then order 0 -> out_order 0, and 1 is never emitted.
// - Gap stall: inject orders 1..5 without 0 -> out_valid stays 0. Then order 0
//   -> out_order 0..5 on 6 consecutive cycles.

Source files
------------

// File: rtl/rvfi_order_serializer.sv
// Reorders NRET out-of-order RVFI retirement channels into one strictly in-order channel.
// Optional same-edge bypass of the head entry: define RVFI_SERIALIZER_BYPASS_EN.
module rvfi_order_serializer #(
  parameter int unsigned NRET      = 2,
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NRET-1:0]           in_valid,
  input  logic [64*NRET-1:0]        in_order,
  input  logic [PAYLOAD_W*NRET-1:0] in_payload,
  output logic                      out_valid,
  output logic [63:0]               out_order,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [63:0]               next_order,
  output logic                      err_dup,
  output logic                      err_ovf
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [63:0]           ch_order   [NRET];
  logic [PAYLOAD_W-1:0]  ch_payload [NRET];
  logic [IdxW-1:0]       ch_idx     [NRET];

  for (genvar g = 0; g < NRET; g++) begin : g_ch
    assign ch_order[g]   = in_order[64*g +: 64];
    assign ch_payload[g] = in_payload[PAYLOAD_W*g +: PAYLOAD_W];
    assign ch_idx[g]     = ch_order[g][IdxW-1:0];
  end

  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [63:0]          slot_order_q   [DEPTH];
  logic [PAYLOAD_W-1:0] slot_payload_q [DEPTH];
  logic [63:0]          next_order_q, next_order_d;
  logic                 out_valid_q, out_valid_d;
  logic [63:0]          out_order_q, out_order_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic                 err_dup_q, err_dup_d;
  logic                 err_ovf_q, err_ovf_d;
  logic [NRET-1:0]      acc;
  logic                 lower_eq;
`ifdef RVFI_SERIALIZER_BYPASS_EN
  logic                 byp_any;
`endif

  logic [IdxW-1:0] head;
  logic [64:0]     win_end;
  assign head    = next_order_q[IdxW-1:0];
  // 65-bit so the window end never wraps near the top of the order space
  assign win_end = {1'b0, next_order_q} + 65'(DEPTH);

  always_comb begin
    vld_d         = vld_q;
    next_order_d  = next_order_q;
    out_valid_d   = 1'b0;
    out_order_d   = out_order_q;
    out_payload_d = out_payload_q;
    err_dup_d     = err_dup_q;
    err_ovf_d     = err_ovf_q;
    acc           = '0;
    lower_eq      = 1'b0;
`ifdef RVFI_SERIALIZER_BYPASS_EN
    byp_any       = 1'b0;
`endif

    if (vld_q[head]) begin
      out_valid_d   = 1'b1;
      out_order_d   = slot_order_q[head];
      out_payload_d = slot_payload_q[head];
      vld_d[head]   = 1'b0;
      next_order_d  = next_order_q + 64'd1;
    end

    for (int i = 0; i < NRET; i++) begin
      lower_eq = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (in_valid[j] && (ch_order[j] == ch_order[i])) lower_eq = 1'b1;
      end
      if (in_valid[i]) begin
        // head can only be targeted while empty, so it never collides with emission
        if ((ch_order[i] < next_order_q) || vld_q[ch_idx[i]] || lower_eq) begin
          err_dup_d = 1'b1;
        end else if ({1'b0, ch_order[i]} >= win_end) begin
          err_ovf_d = 1'b1;
`ifdef RVFI_SERIALIZER_BYPASS_EN
        end else if (!byp_any && (ch_order[i] == next_order_q)) begin
          byp_any       = 1'b1;
          out_valid_d   = 1'b1;
          out_order_d   = ch_order[i];
          out_payload_d = ch_payload[i];
          next_order_d  = next_order_q + 64'd1;
`endif
        end else begin
          vld_d[ch_idx[i]] = 1'b1;
          acc[i]           = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q         <= '0;
      next_order_q  <= '0;
      out_valid_q   <= 1'b0;
      out_order_q   <= '0;
      out_payload_q <= '0;
      err_dup_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      next_order_q  <= next_order_d;
      out_valid_q   <= out_valid_d;
      out_order_q   <= out_order_d;
      out_payload_q <= out_payload_d;
      err_dup_q     <= err_dup_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  // Slot contents are qualified by vld_q, so they need no reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < NRET; i++) begin
      if (acc[i]) begin
        slot_order_q[ch_idx[i]]   <= ch_order[i];
        slot_payload_q[ch_idx[i]] <= ch_payload[i];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_order   = out_order_q;
  assign out_payload = out_payload_q;
  assign next_order  = next_order_q;
  assign err_dup     = err_dup_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_rvfi_order_serializer.sv
// Directed bench for rvfi_order_serializer: reference model keyed by order value plus
// hand-computed literal expectations per scenario.
module tb_rvfi_order_serializer;
  localparam int unsigned NRET  = 2;
  localparam int unsigned PW    = 128;
  localparam int unsigned DEPTH = 8;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic [NRET-1:0]    in_valid = '0;
  logic [64*NRET-1:0] in_order = '0;
  logic [PW*NRET-1:0] in_payload = '0;
  logic               out_valid;
  logic [63:0]        out_order;
  logic [PW-1:0]      out_payload;
  logic [63:0]        next_order;
  logic               err_dup;
  logic               err_ovf;

  rvfi_order_serializer #(
    .NRET     (NRET),
    .PAYLOAD_W(PW),
    .DEPTH    (DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_order   (in_order),
    .in_payload (in_payload),
    .out_valid  (out_valid),
    .out_order  (out_order),
    .out_payload(out_payload),
    .next_order (next_order),
    .err_dup    (err_dup),
    .err_ovf    (err_ovf)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int em_cnt = 0;

  // Model: buffered entries keyed by order value
  logic [PW-1:0]   m_buf [longint unsigned];
  longint unsigned m_next = 0;
  logic            m_ov = 1'b0;
  logic [63:0]     m_oo = '0;
  logic [PW-1:0]   m_op = '0;
  logic            m_dup = 1'b0;
  logic            m_ovf = 1'b0;

  function automatic logic [PW-1:0] pay_of(longint unsigned o, int ch);
    logic [PW-1:0] p;
    p = {~o, o ^ 64'h5a5a_1234_0f0f_a5a5};
    p[100 + ch] = ~p[100 + ch];
    return p;
  endfunction

  task automatic cmp(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit              hit;
    bit              byp_done;
    bit              dup_i;
    logic [PW-1:0]   hp;
    longint unsigned o;
    longint unsigned oj;
    hit = 1'b0;
    byp_done = 1'b0;
    hp = '0;
    if (!reset_n) begin
      m_buf.delete();
      m_next = 0;
      m_ov = 1'b0;
      m_oo = '0;
      m_op = '0;
      m_dup = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    hit = m_buf.exists(m_next);
    if (hit) hp = m_buf[m_next];
    m_ov = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (in_valid[i]) begin
        o = in_order[64*i +: 64];
        dup_i = (o < m_next) || m_buf.exists(o);
        for (int j = 0; j < i; j++) begin
          oj = in_order[64*j +: 64];
          if (in_valid[j] && oj == o) dup_i = 1'b1;
        end
        if (dup_i) m_dup = 1'b1;
        else if (o - m_next >= DEPTH) m_ovf = 1'b1;
`ifdef RVFI_SERIALIZER_BYPASS_EN
        else if (!hit && !byp_done && o == m_next) begin
          byp_done = 1'b1;
          m_ov = 1'b1;
          m_oo = o;
          m_op = in_payload[PW*i +: PW];
        end
`endif
        else m_buf[o] = in_payload[PW*i +: PW];
      end
    end
    if (hit) begin
      m_ov = 1'b1;
      m_oo = m_next;
      m_op = hp;
      m_buf.delete(m_next);
      m_next++;
    end
    if (byp_done) m_next++;
  endtask

  task automatic check_all();
    cmp("out_valid", out_valid, m_ov);
    cmp("out_order", out_order, m_oo);
    cmp("out_payload", out_payload, m_op);
    cmp("next_order", next_order, m_next);
    cmp("err_dup", err_dup, m_dup);
    cmp("err_ovf", err_ovf, m_ovf);
    if (out_valid === 1'b1) em_cnt++;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(bit v0, longint unsigned o0, bit v1, longint unsigned o1);
    in_valid = {v1, v0};
    in_order = {o1, o0};
    in_payload = {pay_of(o1, 1), pay_of(o0, 0)};
    cycle();
    in_valid = '0;
  endtask

  task automatic idle(int n);
    in_valid = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = '0;
    cycle();
    reset_n = 1'b1;
    em_cnt = 0;
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    cycle();
    cycle();
    cmp("rst_valid", out_valid, 0);
    cmp("rst_next", next_order, 0);
    cmp("rst_errs", {err_dup, err_ovf}, 0);
    reset_n = 1'b1;
    em_cnt = 0;

    // In-order single channel
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 2, 0, 0);
    idle(3);
    cmp("inorder_count", em_cnt, 3);
    cmp("inorder_next", next_order, 3);
    cmp("inorder_last", out_order, 2);
    cmp("inorder_dup", err_dup, 0);

    // Swapped channels
    do_reset();
    drive(1, 1, 1, 0);
    drive(1, 3, 1, 2);
    idle(4);
    cmp("swap_count", em_cnt, 4);
    cmp("swap_next", next_order, 4);
    cmp("swap_errs", {err_dup, err_ovf}, 0);

    // Duplicate in one cycle, then stale
    do_reset();
    drive(1, 0, 1, 0);
    idle(2);
    cmp("dup_count", em_cnt, 1);
    cmp("dup_flag", err_dup, 1);
    cmp("dup_payload", out_payload, pay_of(0, 0));
    drive(1, 0, 0, 0);
    idle(2);
    cmp("stale_count", em_cnt, 1);
    cmp("stale_next", next_order, 1);
    cmp("stale_flag", err_dup, 1);

    // Overflow at window edge, order 7 held until 0..6 arrive
    do_reset();
    drive(1, 8, 0, 0);
    cmp("ovf_flag", err_ovf, 1);
    drive(0, 0, 1, 7);
    for (int k = 0; k < 7; k++) drive(1, k, 0, 0);
    idle(3);
    cmp("ovf_count", em_cnt, 8);
    cmp("ovf_next", next_order, 8);
    cmp("ovf_last", out_order, 7);
    cmp("ovf_dup", err_dup, 0);

    // Reset mid-operation
    do_reset();
    drive(1, 1, 1, 2);
    drive(1, 1, 0, 0);
    cmp("mid_pre_dup", err_dup, 1);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cmp("mid_valid", out_valid, 0);
    cmp("mid_next", next_order, 0);
    cmp("mid_errs", {err_dup, err_ovf}, 0);
    em_cnt = 0;
    drive(1, 0, 0, 0);
    idle(4);
    cmp("mid_count", em_cnt, 1);
    cmp("mid_next_after", next_order, 1);

    // Gap stall
    do_reset();
    drive(1, 1, 1, 2);
    drive(1, 3, 1, 4);
    drive(1, 5, 0, 0);
    idle(2);
    cmp("gap_stall", em_cnt, 0);
    drive(0, 0, 1, 0);
    idle(7);
    cmp("gap_count", em_cnt, 6);
    cmp("gap_next", next_order, 6);
    cmp("gap_last", out_order, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
